// File: rtl/uart_frame_responder.sv
// "&&body&&" UART command responder: decodes R/W frames for a 16 x 16-bit register bank and replies.
// Optional rx-silence abort of partial frames when FRAME_TIMEOUT_EN is defined.
module uart_frame_responder
`ifdef FRAME_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
)
`endif
(
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_vld,
    output logic [7:0]  tx_data,
    output logic        tx_req,
    input  logic        tx_done,
    output logic        reg_wr_en,
    output logic [3:0]  reg_addr,
    output logic [15:0] reg_wr_data,
    input  logic [15:0] reg_rd_data,
    output logic        busy,
    output logic        frame_err
);

    localparam logic [7:0] AMP = 8'h26;

    typedef enum logic [2:0] {
        S_IDLE, S_SOF1, S_BODY, S_EOF1, S_EXEC, S_TX, S_WAIT
    } state_t;

    state_t      state, state_nxt;
    logic [7:0]  body [6];
    logic [2:0]  cnt;
    logic        ovf;
    logic [7:0]  reply [9];
    logic [3:0]  idx, last_idx;
    logic        rx_amp;
    logic [1:0]  n_store;
    logic [3:0]  cnt_sum;
    logic        rd_ok, wr_ok;
    logic        tmo;

    function automatic logic is_hex(input logic [7:0] c);
        return (c >= "0" && c <= "9") || (c >= "A" && c <= "F") || (c >= "a" && c <= "f");
    endfunction

    function automatic logic [3:0] hex_val(input logic [7:0] c);
        logic [7:0] d;
        if (c >= "0" && c <= "9")      d = c - 8'h30;
        else if (c >= "A" && c <= "F") d = c - 8'h37;
        else if (c >= "a" && c <= "f") d = c - 8'h57;
        else                           d = '0;
        return d[3:0];
    endfunction

    function automatic logic [7:0] to_hex(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    assign rx_amp      = rx_vld && (rx_data == AMP);
    assign reg_addr    = hex_val(body[1]);
    assign reg_wr_data = {hex_val(body[2]), hex_val(body[3]), hex_val(body[4]), hex_val(body[5])};
    assign busy        = (state != S_IDLE);
    assign tx_data     = reply[idx];

    assign rd_ok = !ovf && (cnt == 3'd2) && (body[0] == "R" || body[0] == "r") && is_hex(body[1]);
    assign wr_ok = !ovf && (cnt == 3'd6) && (body[0] == "W" || body[0] == "w")
                 && is_hex(body[1]) && is_hex(body[2]) && is_hex(body[3])
                 && is_hex(body[4]) && is_hex(body[5]);

`ifdef FRAME_TIMEOUT_EN
    logic [31:0] tmo_cnt;
    logic        in_frame;

    assign in_frame = (state == S_SOF1) || (state == S_BODY) || (state == S_EOF1);
    assign tmo      = in_frame && !rx_vld && (tmo_cnt == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)              tmo_cnt <= '0;
        else if (rx_vld || !in_frame) tmo_cnt <= '0;
        else                          tmo_cnt <= tmo_cnt + 32'd1;
    end
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= S_IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        tx_req    = 1'b0;
        reg_wr_en = 1'b0;
        frame_err = 1'b0;
        case (state)
            S_IDLE: if (rx_amp) state_nxt = S_SOF1;
            S_SOF1: if (rx_vld) state_nxt = rx_amp ? S_BODY : S_IDLE;
            S_BODY: if (rx_amp) state_nxt = S_EOF1;
            S_EOF1: if (rx_vld) state_nxt = rx_amp ? S_EXEC : S_BODY;
            S_EXEC: begin
                reg_wr_en = wr_ok;
                frame_err = !wr_ok && !rd_ok;
                state_nxt = S_TX;
            end
            S_TX: begin
                tx_req    = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT: if (tx_done) state_nxt = (idx == last_idx) ? S_IDLE : S_TX;
            default: state_nxt = S_IDLE;
        endcase
        if (tmo) state_nxt = S_IDLE;
    end

    // A non-'&' after a single '&' in the body means that '&' was data: store both bytes.
    always_comb begin
        n_store = 2'd0;
        if (rx_vld && !rx_amp) begin
            if (state == S_BODY)      n_store = 2'd1;
            else if (state == S_EOF1) n_store = 2'd2;
        end
        cnt_sum = {1'b0, cnt} + {2'b00, n_store};
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            body     <= '{default: '0};
            reply    <= '{default: '0};
            cnt      <= '0;
            ovf      <= 1'b0;
            idx      <= '0;
            last_idx <= '0;
        end else begin
            case (state)
                S_SOF1: if (rx_amp) begin
                    cnt <= '0;
                    ovf <= 1'b0;
                end
                S_BODY, S_EOF1: if (n_store != 2'd0) begin
                    for (int unsigned i = 0; i < 6; i++) begin
                        if (i == 32'(cnt))
                            body[i] <= (state == S_EOF1) ? AMP : rx_data;
                        if (n_store == 2'd2 && i == 32'(cnt) + 32'd1)
                            body[i] <= rx_data;
                    end
                    cnt <= (cnt_sum > 4'd7) ? 3'd7 : cnt_sum[2:0];
                    if (cnt_sum > 4'd6) ovf <= 1'b1;
                end
                S_EXEC: begin
                    idx      <= '0;
                    reply[0] <= AMP;
                    reply[1] <= AMP;
                    if (rd_ok) begin
                        reply[2] <= "D";
                        reply[3] <= to_hex(reg_rd_data[15:12]);
                        reply[4] <= to_hex(reg_rd_data[11:8]);
                        reply[5] <= to_hex(reg_rd_data[7:4]);
                        reply[6] <= to_hex(reg_rd_data[3:0]);
                        reply[7] <= AMP;
                        reply[8] <= AMP;
                        last_idx <= 4'd8;
                    end else begin
                        reply[2] <= wr_ok ? "O" : "E";
                        reply[3] <= wr_ok ? "K" : "R";
                        reply[4] <= AMP;
                        reply[5] <= AMP;
                        last_idx <= 4'd5;
                    end
                end
                S_WAIT: if (tx_done && idx != last_idx) idx <= idx + 4'd1;
                default: ;
            endcase
        end
    end

endmodule
